// File: rtl/fpu_pkg.sv
// Types and constants shared by the fpu block and its requester.
// Operation encoding, the quiet-NaN pattern and the requester FSM states.
package fpu_pkg;

  typedef enum logic [3:0] {
    add_op = 4'd0,
    sub_op = 4'd1,
    mul_op = 4'd2,
    div_op = 4'd3
  } Operation_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RESULT,
    ACK_RESULT,
    RESPOND
  } req_state_t;

  localparam int QNAN_MAX_W = 128;

  // Sign, exponent and mantissa all ones, right-aligned to the requested width.
  function automatic logic [QNAN_MAX_W-1:0] QNAN(input int unsigned w);
    return {QNAN_MAX_W{1'b1}} >> (QNAN_MAX_W - w);
  endfunction

  function automatic logic is_valid_op(input logic [3:0] op);
    return (op == 4'(add_op)) || (op == 4'(sub_op)) ||
           (op == 4'(mul_op)) || (op == 4'(div_op));
  endfunction

endpackage

// File: rtl/fpu_requester.sv
// Single-outstanding initiator for the fpu operand/result handshake.
// Takes tagged commands, runs the fpu handshakes and returns tagged responses.
module fpu_requester
  import fpu_pkg::*;
#(
  parameter int bitness = 32,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [bitness-1:0] cmd_a,
  input  logic [bitness-1:0] cmd_b,
  input  logic [3:0]         cmd_op,
  input  logic [TAG_W-1:0]   cmd_tag,
  output logic               fpu_input_rdy,
  input  logic               fpu_input_ack,
  input  logic               fpu_output_rdy,
  output logic               fpu_output_ack,
  output logic [bitness-1:0] fpu_data_a,
  output logic [bitness-1:0] fpu_data_b,
  output logic [3:0]         fpu_operation,
  input  logic [bitness-1:0] fpu_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [bitness-1:0] rsp_result,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_error,
  output logic               fpu_hung,
  output logic [15:0]        done_count
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [bitness-1:0] QNAN_VAL = bitness'(QNAN(bitness));

  req_state_t          state_reg, state_next;
  logic                alive_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [bitness-1:0]  a_reg, b_reg, result_reg;
  logic [3:0]          op_reg;
  logic [TAG_W-1:0]    tag_reg;
  logic                error_reg, hung_reg;
  logic [15:0]         done_reg;
  logic                accept;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    cmd_ready      = 1'b0;
    fpu_input_rdy  = 1'b0;
    fpu_output_ack = 1'b0;
    rsp_valid      = 1'b0;
    accept         = 1'b0;
    case (state_reg)
      IDLE: begin
        // alive_reg keeps cmd_ready low for the first cycle out of reset
        cmd_ready = alive_reg && !hung_reg;
        accept    = cmd_valid && alive_reg && !hung_reg;
        if (accept) state_next = is_valid_op(cmd_op) ? ISSUE : RESPOND;
      end
      ISSUE: begin
        fpu_input_rdy = 1'b1;
        if (fpu_input_ack) state_next = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        if (fpu_output_rdy)           state_next = ACK_RESULT;
        else if (cnt_reg == CNT_LAST) state_next = RESPOND;
      end
      ACK_RESULT: begin
        fpu_output_ack = 1'b1;
        state_next     = RESPOND;
      end
      RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alive_reg  <= 1'b0;
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      tag_reg    <= '0;
      result_reg <= '0;
      error_reg  <= 1'b0;
      hung_reg   <= 1'b0;
      done_reg   <= '0;
    end else begin
      alive_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            tag_reg <= cmd_tag;
            if (is_valid_op(cmd_op)) begin
              // Subtraction goes to the fpu as an add of the negated operand.
              a_reg     <= cmd_a;
              b_reg     <= (cmd_op == 4'(sub_op)) ? {~cmd_b[bitness-1], cmd_b[bitness-2:0]} : cmd_b;
              op_reg    <= (cmd_op == 4'(sub_op)) ? 4'(add_op) : cmd_op;
              error_reg <= 1'b0;
            end else begin
              error_reg  <= 1'b1;
              result_reg <= QNAN_VAL;
            end
          end
        end
        ISSUE: begin
          if (fpu_input_ack) cnt_reg <= '0;
        end
        WAIT_RESULT: begin
          if (fpu_output_rdy) begin
            result_reg <= fpu_result;
          end else if (cnt_reg == CNT_LAST) begin
            hung_reg   <= 1'b1;
            error_reg  <= 1'b1;
            result_reg <= QNAN_VAL;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        RESPOND: begin
          if (rsp_ready) done_reg <= done_reg + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign fpu_data_a    = a_reg;
  assign fpu_data_b    = b_reg;
  assign fpu_operation = op_reg;
  assign rsp_result    = result_reg;
  assign rsp_tag       = tag_reg;
  assign rsp_error     = error_reg;
  assign fpu_hung      = hung_reg;
  assign done_count    = done_reg;

endmodule

// File: doc/fpu_requester.md
# fpu_requester

Initiator for the FPU operand/result handshake. It accepts a tagged command (two operands plus an operation) on a valid/ready port and drives the FPU's `input_rdy`/`input_ack` and `output_rdy`/`output_ack` pair. It collects the result and returns it with the tag on a valid/ready response port. It sits between the instruction-issue logic and the `fpu` block, one transaction in flight at a time.

## Interface
- `bitness`, 32: operand/result width; passed unchanged to `fpu`.
- `TAG_W`, 4: command tag width.
- `TIMEOUT`, 1024: maximum cycles to wait for `fpu_output_rdy`; must be ≥ 16.
- `clock` in 1: single clock for the whole block.
- `reset` in 1: asynchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when both `cmd_valid` and `cmd_ready` are high at a clock edge.
- `cmd_a`, `cmd_b` in `bitness`: operands.
- `cmd_op` in 4 (`Operation_t`): operation.
- `cmd_tag` in `TAG_W`: returned unchanged with the response.
- `fpu_input_rdy` out 1, `fpu_input_ack` in 1: FPU operand handshake.
- `fpu_output_rdy` in 1, `fpu_output_ack` out 1: FPU result handshake.
- `fpu_data_a`, `fpu_data_b` out `bitness`, `fpu_operation` out 4: FPU operands and operation.
- `fpu_result` in `bitness`: FPU result.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_result` out `bitness`, `rsp_tag` out `TAG_W`: response payload.
- `rsp_error` out 1: 1 = reserved op or timeout.
- `fpu_hung` out 1: sticky; set on timeout.
- `done_count` out 16: completed responses, wraps at 65535→0.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RESULT, ACK_RESULT, RESPOND.
- **IDLE**
  - `cmd_ready = 1` when in IDLE and `fpu_hung = 0`.
  - On accept, latch `a`, `b`, `op`, `tag`.
  - Reserved op (not add, sub, mul, div): go to RESPOND with `rsp_error = 1` and `rsp_result = QNAN`; the FPU is not touched.
  - Otherwise go to ISSUE.
- **Subtraction translation:** `sub_op` is issued as `add_op` with `fpu_data_b` sign bit (bit `bitness-1`) inverted. `add_op`, `mul_op` and `div_op` pass through unchanged.
- **ISSUE**
  - `fpu_input_rdy = 1` for at least one cycle.
  - Leave to WAIT_RESULT on the first edge where `fpu_input_ack` is sampled 1.
  - `fpu_input_ack` is level-sensitive and may remain high from a prior transaction; it is never edge-detected.
- **WAIT_RESULT**
  - Timeout counter runs from 0.
  - `fpu_output_rdy` sampled 1: capture `fpu_result` into `rsp_result` and go to ACK_RESULT.
  - Counter reaches `TIMEOUT-1` with no `fpu_output_rdy`: set `fpu_hung`, `rsp_error = 1`, `rsp_result = QNAN`, go to RESPOND.
- **ACK_RESULT**
  - `fpu_output_ack = 1` for exactly one cycle, then go to RESPOND.
  - Never asserted in any other state.
- **RESPOND**
  - `rsp_valid = 1`; payload is held stable until `rsp_ready` is sampled 1.
  - On that edge: increment `done_count`, go to IDLE.
- **Hung recovery:** `fpu_hung` clears only on reset; while set, `cmd_ready = 0`.
- **FPU operand/operation hold:** `fpu_data_a/b` and `fpu_operation` are driven from the latched command and stay stable from ISSUE through ACK_RESULT.

## Timing
- Reset values (asynchronous, immediate): state IDLE. All outputs 0: `cmd_ready`, `fpu_input_rdy`, `fpu_output_ack`, `rsp_valid`, `rsp_error`, `fpu_hung`, `done_count`, `rsp_result`, `rsp_tag`, `fpu_data_*`, `fpu_operation`.
- Reset deassertion: `cmd_ready` rises on the first cycle after `reset` goes high.
- Cmd accept edge → `fpu_input_rdy` high on the next cycle.
- `fpu_output_rdy` sampled → `fpu_output_ack` high the next cycle → `rsp_valid` high the cycle after.
- Minimum spacing between FPU issues: 3 cycles after `fpu_output_ack`. This guarantees the FPU has returned to accepting input before the next ISSUE.
- Reset asserted mid-transaction: all state is lost and no response is produced. The FPU must be reset at the same time.
- `rsp_ready` held high: response lasts exactly one cycle. Back-to-back commands are accepted on the cycle after the response edge.

## Structure
- Shared package `fpu_pkg`:
  - `Operation_t`, moved out of the `fpu` file and imported by both blocks.
  - `QNAN(bitness)` constant: sign 1, exponent all ones, mantissa all ones.
  - FSM state enum for this block.
- No sub-module; the block is a single FSM plus counters. The timeout counter width is `$clog2(TIMEOUT)`.

## Test plan
1. **Add:** `add_op`, a=0x3F800000, b=0x40000000, tag 3. FPU model returns 0x40400000 → `rsp_result` 0x40400000, tag 3, `rsp_error` 0, `done_count` 1.
2. **Sub translation:** `sub_op`, b=0x40000000 → `fpu_operation` = `add_op` and `fpu_data_b` = 0xC0000000.
3. **Reserved op:** `cmd_op` = 4'b0111 → no `fpu_input_rdy` ever; response with error 1 and result 0xFFFFFFFF.
4. **Sticky ack:** `fpu_input_ack` held 1 permanently → `fpu_input_rdy` lasts exactly one cycle per command. `fpu_output_ack` is a one-cycle pulse.
5. **Timeout:** `TIMEOUT` = 16, FPU model never raises `fpu_output_rdy` → response with error after 16 WAIT cycles. `fpu_hung` = 1 and `cmd_ready` stays 0 until reset.
6. **Back-pressure and reset:** `rsp_ready` low for 5 cycles → payload stable and no new accept. Then assert reset during WAIT_RESULT → all outputs 0 immediately.
